// File: rtl/imem_loadable.sv
// imem_loadable: byte-addressed, big-endian instruction memory.
// LOAD mode streams program bytes in through the load port; load_last moves the
// block to RUN, where whole words are fetched through a valid/ready pipeline
// with one cycle of latency and full backpressure. Misaligned and out-of-range
// fetches return resp_err=1 with a zero instruction.
// Ports:
//   clk, rstn                              clock, synchronous active-low reset
//   load_valid/ready/addr/data/last        byte load stream (LOAD mode only)
//   run_mode                               1 = RUN, 0 = LOAD
//   req_valid/ready/addr                   fetch request (RUN mode only)
//   resp_valid/ready/instr/err             fetch response register
//   fetch_count                            error-free fetches since reset, saturating
module imem_loadable #(
    parameter int unsigned WORD_LEN      = 32,
    parameter int unsigned MEM_CELL_SIZE = 8,
    parameter int unsigned INST_MEM_SIZE = 256
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [$clog2(INST_MEM_SIZE)-1:0] load_addr,
    input  logic [MEM_CELL_SIZE-1:0]      load_data,
    input  logic                          load_last,
    output logic                          run_mode,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [WORD_LEN-1:0]           req_addr,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [WORD_LEN-1:0]           resp_instr,
    output logic                          resp_err,
    output logic [15:0]                   fetch_count
);

    localparam int unsigned BPW = WORD_LEN / MEM_CELL_SIZE;
    localparam int unsigned AW  = $clog2(INST_MEM_SIZE);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [MEM_CELL_SIZE-1:0] r_mem [INST_MEM_SIZE];

    logic                w_run;
    logic                w_load_fire;
    logic                w_accept;
    logic                w_misaligned;
    logic                w_out_of_range;
    logic                w_err;
    logic [AW-1:0]       w_base;
    logic [WORD_LEN-1:0] w_instr;

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and mode decode
    always_comb begin
        w_state_nxt = r_state;
        load_ready  = 1'b0;
        w_run       = 1'b0;
        case (r_state)
            ST_LOAD: begin
                load_ready = 1'b1;
                if (load_valid && load_last) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_run = 1'b1;
            end
            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase
    end

    assign run_mode    = w_run;
    assign w_load_fire = load_valid && load_ready;
    assign req_ready   = w_run && (!resp_valid || resp_ready);
    assign w_accept    = req_valid && req_ready;

    // Range check uses the full address so high bits cannot alias into the array
    assign w_misaligned   = (req_addr % WORD_LEN'(BPW)) != '0;
    assign w_out_of_range = req_addr > WORD_LEN'(INST_MEM_SIZE - BPW);
    assign w_err          = w_misaligned || w_out_of_range;
    assign w_base         = req_addr[AW-1:0];

    // Big-endian word assembly: lowest address lands in the most significant cell
    always_comb begin
        w_instr = '0;
        for (int unsigned i = 0; i < BPW; i++) begin
            w_instr[WORD_LEN-1-i*MEM_CELL_SIZE -: MEM_CELL_SIZE] = r_mem[w_base + AW'(i)];
        end
    end

    // Memory array: no reset so contents survive rstn
    always_ff @(posedge clk) begin
        if (w_load_fire) begin
            r_mem[load_addr] <= load_data;
        end
    end

    // Response register and fetch counter
    always_ff @(posedge clk) begin
        if (!rstn) begin
            resp_valid  <= 1'b0;
            resp_instr  <= '0;
            resp_err    <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (w_accept) begin
                resp_valid <= 1'b1;
                resp_instr <= w_err ? '0 : w_instr;
                resp_err   <= w_err;
                if (!w_err && (fetch_count != 16'hFFFF)) begin
                    fetch_count <= fetch_count + 16'd1;
                end
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule
